ext_unit_pipe: RTL and testbench

//  Parametrised, registered immediate/load-data extension unit with a valid/ready

---
 rtl/ext_unit_pipe.sv | 72 +++++++
 tb/tb_ext_unit_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate/load-data extension unit with valid/ready handshake and 2-entry output buffer
// Parameters: DATA_W result/load width, IMM_W immediate field width, TAG_W sideband width
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   in_valid/in_ready              request handshake
//   in_op                          000 ZEXT, 001 SEXT, 010 LUI, 011 BOFF, 100 LB, 101 LBU, 110 LH, 111 LHU
//   in_data, in_boff, in_tag       immediate or load word, byte offset for loads, sideband tag
//   out_valid/out_ready            result handshake
//   out_data, out_tag, out_err     extended result, returned tag, misaligned-halfword flag
module ext_unit_pipe #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_op,
   input  logic [DATA_W-1:0]             in_data,
   input  logic [$clog2(DATA_W/8)-1:0]   in_boff,
   input  logic [TAG_W-1:0]              in_tag,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [TAG_W-1:0]              out_tag,
   output logic                          out_err
);
   localparam int E_W = DATA_W + TAG_W + 1;
   logic [1:0]        cnt;
   logic [E_W-1:0]    head, tail, new_e;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] sext, res;
   logic [15:0]       half;
   logic              mis, push, pop;
   always_comb begin
      imm  = in_data[IMM_W-1:0];
      sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      // byte/half selected by shifting the addressed byte down to bit 0
      half = 16'(in_data >> {in_boff, 3'b000});
      mis  = in_op[2] & in_op[1] & in_boff[0];
      case (in_op)
         3'd0:    res = {{(DATA_W-IMM_W){1'b0}}, imm};
         3'd1:    res = sext;
         3'd2:    res = {imm, {(DATA_W-IMM_W){1'b0}}};
         3'd3:    res = DATA_W'({sext, 2'b00});
         3'd4:    res = {{(DATA_W-8){half[7]}}, half[7:0]};
         3'd5:    res = {{(DATA_W-8){1'b0}}, half[7:0]};
         3'd6:    res = mis ? '0 : {{(DATA_W-16){half[15]}}, half};
         default: res = mis ? '0 : {{(DATA_W-16){1'b0}}, half};
      endcase
      new_e = {mis, in_tag, res};
   end
   assign in_ready  = cnt != 2'd2;
   assign out_valid = cnt != 2'd0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign {out_err, out_tag, out_data} = head;
   // head is the output register; tail only holds the second entry while full
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) head <= new_e;
         else if (pop && cnt == 2'd2) head <= tail;
         if (push && cnt == 2'd1 && !pop) tail <= new_e;
         cnt <= cnt + {1'b0, push & ~pop} - {1'b0, pop & ~push};
      end
   end
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: directed self-checking bench for ext_unit_pipe
module tb_ext_unit_pipe;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
   logic [2:0]  in_op = '0;
   logic [31:0] in_data = '0, out_data;
   logic [1:0]  in_boff = '0;
   logic [4:0]  in_tag = '0, out_tag;
   int checks = 0, errors = 0;

   ext_unit_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data(in_data), .in_boff(in_boff), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                        input logic [1:0] b, input logic [4:0] t);
      in_valid = v;
      in_op    = op;
      in_data  = d;
      in_boff  = b;
      in_tag   = t;
   endtask

   function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [31:0] d, input logic [1:0] b);
      logic [7:0]  by;
      logic [15:0] h;
      by = d[8*b +: 8];
      h  = b[1] ? d[31:16] : d[15:0];
      case (op)
         3'd0:    ref_ext = {1'b0, 16'h0000, d[15:0]};
         3'd1:    ref_ext = {1'b0, {16{d[15]}}, d[15:0]};
         3'd2:    ref_ext = {1'b0, d[15:0], 16'h0000};
         3'd3:    ref_ext = {1'b0, {14{d[15]}}, d[15:0], 2'b00};
         3'd4:    ref_ext = {1'b0, {24{by[7]}}, by};
         3'd5:    ref_ext = {1'b0, 24'h0, by};
         3'd6:    ref_ext = b[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
         default: ref_ext = b[0] ? {1'b1, 32'h0} : {1'b0, 16'h0, h};
      endcase
   endfunction

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got v=%b r=%b d=%h t=%h e=%b exp v=0 r=1 d=0 t=0 e=0",
                  out_valid, in_ready, out_data, out_tag, out_err);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_modes;
      logic [31:0] exp_d [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
      out_ready = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i-1] || out_tag !== 5'(i) || out_err !== 1'b0) begin
               errors++;
               $display("FAIL mode_%0d got v=%b d=%h t=%0d e=%b exp v=1 d=%h t=%0d e=0",
                        i-1, out_valid, out_data, out_tag, out_err, exp_d[i-1], i);
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mode_ready got %b exp 1", in_ready);
         end
         if (i < 4) drive(1'b1, 3'(i), 32'hA5A58001, 2'd3, 5'(i+1));
         else drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mode_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_loads;
      logic [2:0]  ops  [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd7};
      logic [1:0]  offs [6] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
      logic [31:0] exp_d[6] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0, 32'h0};
      logic        exp_e[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i-1] || out_err !== exp_e[i-1] || out_tag !== 5'(i+8)) begin
               errors++;
               $display("FAIL load_%0d got v=%b d=%h e=%b t=%0d exp v=1 d=%h e=%b t=%0d",
                        i-1, out_valid, out_data, out_err, out_tag, exp_d[i-1], exp_e[i-1], i+8);
            end
         end
         if (i < 6) drive(1'b1, ops[i], 32'h80FF7F01, offs[i], 5'(i+9));
         else drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [31:0] held;
      out_ready = 1'b0;
      @(negedge clk);
      drive(1'b1, 3'd0, 32'h11, 2'd0, 5'd1);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
         errors++;
         $display("FAIL bp_first got r=%b v=%b t=%0d exp r=1 v=1 t=1", in_ready, out_valid, out_tag);
      end
      drive(1'b1, 3'd0, 32'h22, 2'd0, 5'd2);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full got r=%b exp 0", in_ready);
      end
      drive(1'b1, 3'd0, 32'h33, 2'd0, 5'd3);
      held = out_data;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_data !== 32'h11 || out_data !== held) begin
         errors++;
         $display("FAIL bp_hold got r=%b t=%0d d=%h exp r=0 t=1 d=00000011", in_ready, out_tag, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'h22 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_second got v=%b t=%0d d=%h r=%b exp v=1 t=2 d=00000022 r=1",
                  out_valid, out_tag, out_data, in_ready);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h33) begin
         errors++;
         $display("FAIL bp_third got v=%b t=%0d d=%h exp v=1 t=3 d=00000033", out_valid, out_tag, out_data);
      end
      drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(1'b1, 3'd1, 32'h0000F00D, 2'd0, 5'd20);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'hFFFFF00D) begin
         errors++;
         $display("FAIL b2b_one got v=%b r=%b d=%h exp v=1 r=1 d=fffff00d", out_valid, in_ready, out_data);
      end
      out_ready = 1'b1;
      drive(1'b1, 3'd2, 32'h00001234, 2'd0, 5'd21);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h12340000 || out_tag !== 5'd21) begin
         errors++;
         $display("FAIL b2b_swap got v=%b r=%b d=%h t=%0d exp v=1 r=1 d=12340000 t=21",
                  out_valid, in_ready, out_data, out_tag);
      end
      drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_streaming;
      logic [32:0] exp_r [100];
      logic [4:0]  exp_t [100];
      logic [2:0]  op;
      logic [31:0] d;
      logic [1:0]  b;
      out_ready = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || {out_err, out_data} !== exp_r[i-1] || out_tag !== exp_t[i-1]) begin
               errors++;
               $display("FAIL stream_%0d got v=%b e=%b d=%h t=%0d exp v=1 e=%b d=%h t=%0d",
                        i-1, out_valid, out_err, out_data, out_tag, exp_r[i-1][32], exp_r[i-1][31:0], exp_t[i-1]);
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready got %b exp 1", in_ready);
         end
         if (i < 100) begin
            op = 3'($urandom_range(0, 7));
            d  = $urandom;
            b  = 2'($urandom_range(0, 3));
            exp_r[i] = ref_ext(op, d, b);
            exp_t[i] = 5'(i);
            drive(1'b1, op, d, b, 5'(i));
         end else drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'h0000BEEF, 2'd0, 5'd7);
      @(negedge clk);
      drive(1'b1, 3'd0, 32'h0000CAFE, 2'd0, 5'd8);
      @(negedge clk);
      drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0000BEEF) begin
         errors++;
         $display("FAIL arst_full got r=%b v=%b d=%h exp r=0 v=1 d=0000beef", in_ready, out_valid, out_data);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || out_tag !== 5'h0) begin
         errors++;
         $display("FAIL arst_immediate got v=%b d=%h r=%b t=%0d exp v=0 d=0 r=1 t=0",
                  out_valid, out_data, in_ready, out_tag);
      end
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL arst_lost got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset;
      test_modes;
      test_loads;
      test_backpressure;
      test_back_to_back;
      test_streaming;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
